ksa_pipe: RTL

- Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready handshakes on input and output.
- Next generation of the team's 16-bit combinational KSA: configurable width, configurable prefix levels per pipeline stage, add/sub mode, and status flags.
- Sits in datapath/ALU clusters where a full-width single-cycle carry chain misses timing; sustains one operation per cycle.

---
 rtl/ksa_pipe.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshakes.
// LVL_PER_STAGE prefix levels sit between registers; one beat per cycle when not stalled.
module ksa_pipe #(
    parameter int WIDTH         = 16,
    parameter int LVL_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int LOG  = $clog2(WIDTH);
    localparam int NSTG = (LOG + LVL_PER_STAGE - 1) / LVL_PER_STAGE;

    logic             stall;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g0;
    logic             cx;

    logic [WIDTH-1:0] s0_g, s0_p;
    logic             s0_c, s0_v;

    logic [WIDTH-1:0] gr [0:NSTG];
    logic [WIDTH-1:0] pr [0:NSTG];
    logic [WIDTH-1:0] hr [0:NSTG];
    logic             cr [0:NSTG];
    logic             vr [0:NSTG];

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    assign bx = sub ? ~b : b;
    assign cx = sub ? ~cin : cin;

    // Carry-in is folded into bit 0's generate so every prefix level carries it upward.
    always_comb begin
        g0    = a & bx;
        g0[0] = (a[0] & bx[0]) | ((a[0] ^ bx[0]) & cx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v <= 1'b0;
            s0_g <= '0;
            s0_p <= '0;
            s0_c <= 1'b0;
        end else if (!stall) begin
            s0_v <= in_valid;
            s0_g <= g0;
            s0_p <= a ^ bx;
            s0_c <= cx;
        end
    end

    assign gr[0] = s0_g;
    assign pr[0] = s0_p;
    assign hr[0] = s0_p;
    assign cr[0] = s0_c;
    assign vr[0] = s0_v;

    for (genvar s = 0; s < NSTG; s++) begin : g_stage
        localparam int L0 = s * LVL_PER_STAGE;
        localparam int L1 = (L0 + LVL_PER_STAGE > LOG) ? LOG : L0 + LVL_PER_STAGE;

        logic [WIDTH-1:0] gc, pc;
        logic [WIDTH-1:0] gq, pq, hq;
        logic             cq, vq;

        // Walking bits downward lets each level update in place from the previous level's values.
        always_comb begin
            gc = gr[s];
            pc = pr[s];
            for (int k = L0; k < L1; k++) begin
                for (int i = WIDTH - 1; i >= (1 << k); i--) begin
                    gc[i] = gc[i] | (pc[i] & gc[i - (1 << k)]);
                    pc[i] = pc[i] & pc[i - (1 << k)];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vq <= 1'b0;
                gq <= '0;
                pq <= '0;
                hq <= '0;
                cq <= 1'b0;
            end else if (!stall) begin
                vq <= vr[s];
                gq <= gc;
                pq <= pc;
                hq <= hr[s];
                cq <= cr[s];
            end
        end

        assign gr[s+1] = gq;
        assign pr[s+1] = pq;
        assign hr[s+1] = hq;
        assign cr[s+1] = cq;
        assign vr[s+1] = vq;
    end

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;

    assign carry = {gr[NSTG][WIDTH-2:0], cr[NSTG]};
    assign sum_d = hr[NSTG] ^ carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (!stall) begin
            out_valid <= vr[NSTG];
            sum       <= sum_d;
            cout      <= gr[NSTG][WIDTH-1];
            ovf       <= gr[NSTG][WIDTH-1] ^ carry[WIDTH-1];
            zero      <= ~|sum_d;
        end
    end

endmodule
